// File: rtl/dmem_arb_pkg.sv
// =============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-RAM arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;
    localparam int CONFLICT_W = 16;
    // Wide enough for the largest legal STARVE_MAX (15).
    localparam int STREAK_W   = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P    = 2'd1,
        OWN_IO   = 2'd2
    } owner_e;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_fairness.sv
// =============================================================================
// Module      : dmem_arb_fairness
// Description : Processor-priority grant decision with a bounded I/O starvation streak.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module dmem_arb_fairness
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic p_req,
    input  logic io_req,
    output logic gnt_p,
    output logic gnt_io
);

    localparam logic [STREAK_W-1:0] C_STARVE = STREAK_W'(STARVE_MAX);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;

    always_comb begin
        gnt_p    = 1'b0;
        gnt_io   = 1'b0;
        streak_d = streak_q;
        if (reset) begin
            if (p_req && io_req) begin
                // Contested: processor wins until the streak reaches its limit.
                if (streak_q >= C_STARVE) begin
                    gnt_io   = 1'b1;
                    streak_d = '0;
                end else begin
                    gnt_p    = 1'b1;
                    streak_d = streak_q + 1'b1;
                end
            end else if (p_req) begin
                gnt_p    = 1'b1;
                streak_d = '0;
            end else if (io_req) begin
                gnt_io   = 1'b1;
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// =============================================================================
// Module      : dmem_arbiter
// Description : Shares one data RAM between the processor and the game I/O engine.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  p_req,
    input  logic                  p_wen,
    input  logic [ADDR_W-1:0]     p_addr,
    input  logic [DATA_W-1:0]     p_wdata,
    output logic                  p_gnt,
    output logic                  p_rvalid,
    output logic [DATA_W-1:0]     p_rdata,
    input  logic                  io_req,
    input  logic                  io_wen,
    input  logic [ADDR_W-1:0]     io_addr,
    input  logic [DATA_W-1:0]     io_wdata,
    output logic                  io_gnt,
    output logic                  io_rvalid,
    output logic [DATA_W-1:0]     io_rdata,
    output logic                  ram_wEn,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_dataIn,
    input  logic [DATA_W-1:0]     ram_dataOut,
    output logic [CONFLICT_W-1:0] conflict_cnt
);

    owner_e                owner_q;
    owner_e                owner_d;
    logic [CONFLICT_W-1:0] conflict_q;
    logic [CONFLICT_W-1:0] conflict_d;

    dmem_arb_fairness #(
        .STARVE_MAX (STARVE_MAX)
    ) u_fairness (
        .clock  (clock),
        .reset  (reset),
        .p_req  (p_req),
        .io_req (io_req),
        .gnt_p  (p_gnt),
        .gnt_io (io_gnt)
    );

    always_comb begin
        ram_wEn    = 1'b0;
        ram_addr   = '0;
        ram_dataIn = '0;
        if (p_gnt) begin
            ram_wEn    = p_wen;
            ram_addr   = p_addr;
            ram_dataIn = p_wdata;
        end else if (io_gnt) begin
            ram_wEn    = io_wen;
            ram_addr   = io_addr;
            ram_dataIn = io_wdata;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (p_gnt && !p_wen) begin
            owner_d = OWN_P;
        end else if (io_gnt && !io_wen) begin
            owner_d = OWN_IO;
        end
    end

    always_comb begin
        conflict_d = conflict_q;
        if (p_req && io_req && (conflict_q != {CONFLICT_W{1'b1}})) begin
            conflict_d = conflict_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q    <= OWN_NONE;
            conflict_q <= '0;
        end else begin
            owner_q    <= owner_d;
            conflict_q <= conflict_d;
        end
    end

    // RAM output is only forwarded to the port that issued the read last cycle.
    assign p_rvalid     = (owner_q == OWN_P);
    assign io_rvalid    = (owner_q == OWN_IO);
    assign p_rdata      = (owner_q == OWN_P)  ? ram_dataOut : '0;
    assign io_rdata     = (owner_q == OWN_IO) ? ram_dataOut : '0;
    assign conflict_cnt = conflict_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// =============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a registered-read RAM model.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        p_req, p_wen, p_gnt, p_rvalid;
    logic [11:0] p_addr;
    logic [31:0] p_wdata, p_rdata;
    logic        io_req, io_wen, io_gnt, io_rvalid;
    logic [11:0] io_addr;
    logic [31:0] io_wdata, io_rdata;
    logic        ram_wEn;
    logic [11:0] ram_addr;
    logic [31:0] ram_dataIn, ram_dataOut;
    logic [15:0] conflict_cnt;

    logic [31:0] mem [0:4095];

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter #(
        .ADDR_W     (12),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .p_req        (p_req),
        .p_wen        (p_wen),
        .p_addr       (p_addr),
        .p_wdata      (p_wdata),
        .p_gnt        (p_gnt),
        .p_rvalid     (p_rvalid),
        .p_rdata      (p_rdata),
        .io_req       (io_req),
        .io_wen       (io_wen),
        .io_addr      (io_addr),
        .io_wdata     (io_wdata),
        .io_gnt       (io_gnt),
        .io_rvalid    (io_rvalid),
        .io_rdata     (io_rdata),
        .ram_wEn      (ram_wEn),
        .ram_addr     (ram_addr),
        .ram_dataIn   (ram_dataIn),
        .ram_dataOut  (ram_dataOut),
        .conflict_cnt (conflict_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] init_val(input logic [11:0] a);
        return 32'hC0DE_0000 | {20'h0, a};
    endfunction

    // Registered-read RAM: read returns pre-write contents of the same edge.
    always @(posedge clock) begin
        if (ram_wEn) mem[ram_addr] <= ram_dataIn;
        ram_dataOut <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pr, input logic pw, input logic [11:0] pa, input logic [31:0] pd,
                         input logic ir, input logic iw, input logic [11:0] ia, input logic [31:0] id);
        @(negedge clock);
        p_req  = pr; p_wen  = pw; p_addr  = pa; p_wdata  = pd;
        io_req = ir; io_wen = iw; io_addr = ia; io_wdata = id;
        #1;
    endtask

    initial begin : stim
        logic        prev_p, prev_io;
        logic [11:0] pa, ia, prev_pa, prev_ia;
        logic        exp_io;

        for (int i = 0; i < 4096; i++) mem[i] = init_val(12'(i));
        ram_dataOut = '0;
        reset = 1'b0;
        p_req = 1'b1; p_wen = 1'b0; p_addr = 12'h001; p_wdata = '0;
        io_req = 1'b1; io_wen = 1'b0; io_addr = 12'h002; io_wdata = '0;

        // Reset held for 3 cycles with both requesting
        repeat (3) @(negedge clock);
        #1;
        chk("rst_p_gnt", p_gnt, 0);
        chk("rst_io_gnt", io_gnt, 0);
        chk("rst_rvalid", {p_rvalid, io_rvalid}, 0);
        chk("rst_ram_wEn", ram_wEn, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_conflict", conflict_cnt, 0);

        // Contention: 10 contested reads starting at reset release
        @(negedge clock);
        reset = 1'b1;
        pa = 12'h100; ia = 12'h200;
        prev_p = 1'b0; prev_io = 1'b0; prev_pa = '0; prev_ia = '0;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) begin
                @(negedge clock);
            end
            p_req = 1'b1; p_wen = 1'b0; p_addr = pa;
            io_req = 1'b1; io_wen = 1'b0; io_addr = ia;
            #1;
            exp_io = ((i % 5) == 4);
            chk($sformatf("cont_p_gnt_%0d", i), p_gnt, !exp_io);
            chk($sformatf("cont_io_gnt_%0d", i), io_gnt, exp_io);
            chk($sformatf("cont_p_rvalid_%0d", i), p_rvalid, prev_p);
            chk($sformatf("cont_io_rvalid_%0d", i), io_rvalid, prev_io);
            chk($sformatf("cont_p_rdata_%0d", i), p_rdata, prev_p ? init_val(prev_pa) : 32'h0);
            chk($sformatf("cont_io_rdata_%0d", i), io_rdata, prev_io ? init_val(prev_ia) : 32'h0);
            prev_p = !exp_io; prev_io = exp_io; prev_pa = pa; prev_ia = ia;
            if (exp_io) ia = ia + 12'h1;
            else        pa = pa + 12'h1;
        end
        drive(0, 0, 12'h000, 0, 0, 0, 12'h000, 0);
        chk("cont_last_io_rvalid", io_rvalid, 1);
        chk("cont_last_io_rdata", io_rdata, init_val(12'h201));
        chk("cont_last_p_rvalid", p_rvalid, 0);
        chk("cont_conflict_10", conflict_cnt, 10);

        // Processor write then read
        drive(1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 12'h000, 0);
        chk("pw_gnt", p_gnt, 1);
        chk("pw_ram_wEn", ram_wEn, 1);
        chk("pw_ram_addr", ram_addr, 12'h010);
        chk("pw_ram_dataIn", ram_dataIn, 32'hDEADBEEF);
        drive(1, 0, 12'h010, 0, 0, 0, 12'h000, 0);
        chk("pr_gnt", p_gnt, 1);
        chk("pr_no_rvalid_after_write", p_rvalid, 0);
        chk("pr_ram_wEn", ram_wEn, 0);
        drive(0, 0, 12'h000, 0, 0, 0, 12'h000, 0);
        chk("pr_rvalid", p_rvalid, 1);
        chk("pr_rdata", p_rdata, 32'hDEADBEEF);
        chk("pr_io_rvalid", io_rvalid, 0);
        chk("pr_io_rdata", io_rdata, 0);
        chk("idle_ram_addr", ram_addr, 0);

        // Cross-port coherence and top-of-memory read
        drive(0, 0, 12'h000, 0, 1, 1, 12'h020, 32'h5);
        chk("iow_gnt", io_gnt, 1);
        chk("iow_ram_wEn", ram_wEn, 1);
        chk("iow_ram_dataIn", ram_dataIn, 32'h5);
        drive(1, 0, 12'h020, 0, 0, 0, 12'h000, 0);
        chk("xr_p_gnt", p_gnt, 1);
        drive(0, 0, 12'h000, 0, 1, 0, 12'hFFF, 0);
        chk("xr_io_gnt", io_gnt, 1);
        chk("xr_p_rvalid", p_rvalid, 1);
        chk("xr_p_rdata", p_rdata, 32'h5);
        drive(0, 0, 12'h000, 0, 0, 0, 12'h000, 0);
        chk("fff_io_rvalid", io_rvalid, 1);
        chk("fff_io_rdata", io_rdata, init_val(12'hFFF));
        chk("fff_p_rvalid", p_rvalid, 0);

        // Reset mid-read with a nonzero streak
        drive(1, 0, 12'h030, 0, 1, 0, 12'h040, 0);
        chk("mr_p_gnt", p_gnt, 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("mr_p_rvalid", p_rvalid, 0);
        chk("mr_p_rdata", p_rdata, 0);
        chk("mr_gnt_in_reset", {p_gnt, io_gnt}, 0);
        chk("mr_conflict", conflict_cnt, 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rel_p_gnt", p_gnt, 1);
        chk("rel_io_gnt", io_gnt, 0);
        chk("rel_p_rvalid", p_rvalid, 0);
        for (int i = 1; i < 5; i++) begin
            drive(1, 0, 12'h030, 0, 1, 0, 12'h040, 0);
            chk($sformatf("rel_io_gnt_%0d", i), io_gnt, (i == 4));
        end
        drive(0, 0, 12'h000, 0, 0, 0, 12'h000, 0);
        chk("rel_io_rvalid", io_rvalid, 1);
        chk("rel_io_rdata", io_rdata, init_val(12'h040));
        chk("rel_conflict_5", conflict_cnt, 5);

        // Saturation of the conflict counter
        drive(1, 0, 12'h000, 0, 1, 0, 12'h001, 0);
        repeat (70000) @(negedge clock);
        #1;
        chk("sat_conflict", conflict_cnt, 32'h0000FFFF);
        drive(0, 0, 12'h000, 0, 0, 0, 12'h000, 0);
        chk("sat_conflict_hold", conflict_cnt, 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single data RAM between the processor's data-memory port and the game I/O engine's port (sprite/score tables). It sits between `processor`/peripheral and `RAM`, replacing the direct processor-to-RAM connection. Processor has priority; a streak counter bounds I/O starvation. Read data is routed back to the owner one cycle after its grant.

## Interface
- `ADDR_W`, 12: RAM address width.
- `DATA_W`, 32: data width.
- `STARVE_MAX`, 4: consecutive contested processor grants before I/O is forced a grant; legal range 1..15.
- `clock` in 1: single clock, posedge.
- `reset` in 1: asynchronous, active-low.
- `p_req` in 1: processor access request.
- `p_wen` in 1: processor write (1) or read (0).
- `p_addr` in ADDR_W: processor address.
- `p_wdata` in DATA_W: processor write data.
- `p_gnt` out 1: processor granted this cycle.
- `p_rvalid` out 1: processor read data valid.
- `p_rdata` out DATA_W: processor read data.
- `io_req`, `io_wen`, `io_addr`, `io_wdata`, `io_gnt`, `io_rvalid`, `io_rdata`: same as the `p_*` ports, for the I/O engine.
- `ram_wEn` out 1: RAM write enable.
- `ram_addr` out ADDR_W: RAM address.
- `ram_dataIn` out DATA_W: RAM write data.
- `ram_dataOut` in DATA_W: RAM read data, registered by RAM, valid one cycle after address.
- `conflict_cnt` out 16: saturating count of cycles with both requests high.

## Operation
- At most one grant per cycle. `p_gnt` and `io_gnt` are combinational from `p_req`, `io_req`, `streak`, and reset.
- Only `p_req`: grant p, `streak`←0.
- Only `io_req`: grant io, `streak`←0.
- Both, `streak` < STARVE_MAX: grant p, `streak`++.
- Both, `streak` == STARVE_MAX: grant io, `streak`←0.
- Neither: no grant, `streak` unchanged.
- RAM mux:
  - Granted side drives `ram_addr`, `ram_dataIn`, and `ram_wEn` = its `wen`.
  - No grant: `ram_wEn`=0, `ram_addr`=0, `ram_dataIn`=0.
- Read return:
  - On a granted read, register `owner` ∈ {NONE, P, IO}; otherwise `owner`←NONE.
  - Next cycle, `<owner>_rvalid`=1 and `<owner>_rdata`=`ram_dataOut`.
  - Non-owner `rdata` is 0 and `rvalid` is 0.
- Writes produce no `rvalid`.
- Requester rule: hold `req`/`wen`/`addr`/`wdata` stable until a posedge at which its `gnt`=1. A dropped request before grant is legal and has no effect.
- `conflict_cnt` increments on each `p_req & io_req` cycle, including during reset release. It saturates at 0xFFFF.

## Timing
- Grant latency 0 cycles (same cycle as `req`). Write commits at that posedge.
- Read latency 1 cycle: `rvalid` is high the cycle after the grant cycle. Throughput is 1 access/cycle; back-to-back reads pipeline.
- Read the cycle after a write to the same address, from either port, returns the new data.
- Reset low, asynchronously:
  - `streak`=0, `owner`=NONE, `conflict_cnt`=0.
  - All `gnt`, `rvalid`, `rdata`, and `ram_*` outputs are 0.
  - A read granted before reset never returns `rvalid`.
- First cycle after reset release: both requests → p granted.

## Structure
- Package `dmem_arb_pkg`: owner enum (`OWN_NONE`, `OWN_P`, `OWN_IO`), default `ADDR_W`/`DATA_W`, `CONFLICT_W`=16.
- One sub-module, `dmem_arb_fairness`: streak counter plus grant decision. Outputs `gnt_p`/`gnt_io`.
- Top level holds the RAM mux, `owner` register, return routing and `conflict_cnt`.

## Test plan
- **Reset:** hold reset low 3 cycles with both `req` high → all `gnt`/`rvalid`/`ram_wEn`=0, `conflict_cnt`=0.
- **Processor write then read:** p writes 0x010=0xDEADBEEF, then p reads 0x010 → `p_gnt`=1 both cycles. Next cycle `p_rvalid`=1, `p_rdata`=0xDEADBEEF; `io_rvalid`=0.
- **Contention:** STARVE_MAX=4, both reading continuously for 10 cycles → grant order P,P,P,P,IO,P,P,P,P,IO; each `rvalid` lands on the correct port one cycle later; `conflict_cnt`=10.
- **Cross-port coherence:** io writes 0x020=5, p reads 0x020 next cycle → `p_rdata`=5. io reads 0xFFF → `io_rvalid` one cycle later with RAM[0xFFF].
- **Reset mid-read:** reset low in the cycle after p's read grant → `p_rvalid` stays 0. After release, both requesting → p granted, `streak` restarts at 0.
- **Saturation:** force 70000 contested cycles → `conflict_cnt` holds 0xFFFF.
